// File: rtl/mul_pkg.sv
// mul_pkg: shared FSM state type and default widths for the mul multiply-accumulate datapath
package mul_pkg;
   localparam int RES_WIDTH   = 64;
   localparam int ACC_WIDTH   = 72;
   localparam int COUNT_WIDTH = 8;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
endpackage

// File: rtl/mul_acc_if.sv
// mul_acc_if: batch control, mul read handshake and sum valid/ready bundle for mul_acc
interface mul_acc_if #(
   parameter int RES_WIDTH   = mul_pkg::RES_WIDTH,
   parameter int ACC_WIDTH   = mul_pkg::ACC_WIDTH,
   parameter int COUNT_WIDTH = mul_pkg::COUNT_WIDTH
);
   logic                   start;
   logic [COUNT_WIDTH-1:0] len;
   logic                   mul_rd_ready;
   logic                   mul_rd_val;
   logic [RES_WIDTH-1:0]   mul_rd_data;
   logic                   mul_rd_en;
   logic                   busy;
   logic [ACC_WIDTH-1:0]   sum;
   logic                   sum_val;
   logic                   sum_ready;
   logic                   overflow;
   logic                   err;
   modport master (
      output start, len, mul_rd_ready, mul_rd_val, mul_rd_data, sum_ready,
      input  mul_rd_en, busy, sum, sum_val, overflow, err
   );
   modport slave (
      input  start, len, mul_rd_ready, mul_rd_val, mul_rd_data, sum_ready,
      output mul_rd_en, busy, sum, sum_val, overflow, err
   );
endinterface

// File: rtl/mul_acc_adder.sv
// mul_acc_adder: accumulator-wide adder of a zero-extended product, with carry out
module mul_acc_adder #(
   parameter int RES_WIDTH = 64,
   parameter int ACC_WIDTH = 72
) (
   input  logic [ACC_WIDTH-1:0] a,
   input  logic [RES_WIDTH-1:0] b,
   output logic [ACC_WIDTH-1:0] s,
   output logic                 c
);
   assign {c, s} = {1'b0, a} + {{(ACC_WIDTH + 1 - RES_WIDTH){1'b0}}, b};
endmodule

// File: rtl/mul_acc.sv
// mul_acc: drains len products from mul and presents their sum; MUL_ACC_TIMEOUT_EN adds a WAIT read timeout
module mul_acc #(
   parameter int RES_WIDTH   = mul_pkg::RES_WIDTH,
   parameter int ACC_WIDTH   = mul_pkg::ACC_WIDTH,
   parameter int COUNT_WIDTH = mul_pkg::COUNT_WIDTH,
   parameter int TIMEOUT     = 255
) (
   input logic      clk,
   input logic      reset,
   mul_acc_if.slave bus
);
   import mul_pkg::*;
   state_t                 state;
   logic [COUNT_WIDTH-1:0] len_q, count, count_nx;
   logic [ACC_WIDTH-1:0]   sum, add_sum;
   logic                   add_carry, overflow, err, rd_en, timed_out;
   assign count_nx = count + 1'b1;
   mul_acc_adder #(.RES_WIDTH(RES_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_add (
      .a(sum),
      .b(bus.mul_rd_data),
      .s(add_sum),
      .c(add_carry)
   );
`ifdef MUL_ACC_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] wait_cnt;
   assign timed_out = wait_cnt == TW'(TIMEOUT - 1);
   // Cycles spent in WAIT without data; restarts every time WAIT is entered
   always_ff @(posedge clk)
      wait_cnt <= (reset || state != WAIT) ? '0 : wait_cnt + 1'b1;
`else
   logic unused_timeout;
   assign unused_timeout = |TIMEOUT;
   assign timed_out = 1'b0;
`endif
   // Batch FSM: one read per product, accumulate accepted data, hold the total until taken.
   // A zero-length batch passes through REQ, which sees count==len and finishes without reading.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         len_q    <= '0;
         count    <= '0;
         sum      <= '0;
         overflow <= 1'b0;
         err      <= 1'b0;
         rd_en    <= 1'b0;
      end else begin
         rd_en <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               len_q    <= bus.len;
               count    <= '0;
               sum      <= '0;
               overflow <= 1'b0;
               err      <= 1'b0;
               state    <= REQ;
            end
            REQ: if (count == len_q) state <= DONE;
               else if (bus.mul_rd_ready) begin
                  rd_en <= 1'b1;
                  state <= WAIT;
               end
            WAIT: if (bus.mul_rd_val) begin
                  sum      <= add_sum;
                  overflow <= overflow | add_carry;
                  count    <= count_nx;
                  state    <= count_nx == len_q ? DONE : REQ;
               end else if (timed_out) begin
                  err   <= 1'b1;
                  state <= DONE;
               end
            DONE: if (bus.sum_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
   assign bus.mul_rd_en = rd_en;
   assign bus.busy      = state != IDLE;
   assign bus.sum_val   = state == DONE;
   assign bus.sum       = sum;
   assign bus.overflow  = overflow;
   assign bus.err       = err;
endmodule
